// File: rtl/mode_sequencer_pkg.sv
// Shared types and constants for the display mode sequencer.
package mode_sequencer_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FADE_OUT = 2'd1,
        SWITCH   = 2'd2,
        FADE_IN  = 2'd3
    } seq_state_t;

    typedef logic [3:0] mode_t;

    localparam logic [2:0] FADE_MAX  = 3'd7;
    localparam logic [9:0] FRAME_MAX = 10'd1023;

    // Next mode in the cycle 0..num_modes-1, wrapping back to 0.
    function automatic mode_t next_mode(input mode_t m, input int unsigned num_modes);
        if (m == mode_t'(num_modes - 1)) begin
            return '0;
        end
        return m + 4'd1;
    endfunction

endpackage

// File: rtl/mode_sequencer_frame_divider.sv
// Divides vsync_pulse by STEP_FRAMES; step_tick marks the frame that completes a fade step.
module mode_sequencer_frame_divider #(
    parameter int unsigned STEP_FRAMES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic vsync_pulse,
    output logic step_tick
);

    localparam int unsigned CW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_FRAMES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Frame counter; clear (state entry) restarts the step phase.
    always_comb begin
        cnt_d     = cnt_q;
        step_tick = vsync_pulse && (cnt_q == LAST);
        if (clear) begin
            cnt_d = '0;
        end else if (vsync_pulse) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mode_sequencer.sv
// Frame-aligned mode scheduler: turns phrase/crotchet events into mode changes
// with a fade-out / switch / fade-in sequence, plus frame, beat and flash outputs.
module mode_sequencer
    import mode_sequencer_pkg::*;
#(
    parameter int unsigned NUM_MODES        = 14,
    parameter int unsigned FADE_STEP_FRAMES = 2,
    parameter int unsigned FLASH_FRAMES     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       crotchet,
    input  logic       phrase,
    input  logic       vsync_pulse,
    input  logic       hold,
    output logic [3:0] mode,
    output logic [9:0] frame,
    output logic [1:0] beat,
    output logic       beat_flash,
    output logic [2:0] fade,
    output logic       busy,
    output seq_state_t state_dbg
);

    seq_state_t state_q, state_d;
    mode_t      mode_q, mode_d;
    logic [9:0] frame_q, frame_d;
    logic [1:0] beat_q, beat_d;
    logic [3:0] flash_cnt_q, flash_cnt_d;
    logic [2:0] fade_q, fade_d;
    logic       pending_q, pending_d;
    logic       step_tick;
    logic       state_change;

    assign state_change = (state_d != state_q);

    mode_sequencer_frame_divider #(
        .STEP_FRAMES(FADE_STEP_FRAMES)
    ) u_frame_divider (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_change),
        .vsync_pulse(vsync_pulse),
        .step_tick  (step_tick)
    );

    // All state registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            mode_q      <= '0;
            frame_q     <= '0;
            beat_q      <= '0;
            flash_cnt_q <= '0;
            fade_q      <= FADE_MAX;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            frame_q     <= frame_d;
            beat_q      <= beat_d;
            flash_cnt_q <= flash_cnt_d;
            fade_q      <= fade_d;
            pending_q   <= pending_d;
        end
    end

    // Next-state logic; the sequencer only moves on frame boundaries.
    always_comb begin
        state_d = state_q;
        if (vsync_pulse) begin
            case (state_q)
                RUN:      if ((pending_q || phrase) && !hold) state_d = FADE_OUT;
                FADE_OUT: if (step_tick && fade_q == 3'd1) state_d = SWITCH;
                SWITCH:   state_d = FADE_IN;
                FADE_IN:  if (step_tick && fade_q == FADE_MAX - 3'd1) state_d = RUN;
                default:  state_d = RUN;
            endcase
        end
    end

    // Datapath: fade level, mode/frame counters, pending request, beat and flash.
    always_comb begin
        fade_d      = fade_q;
        mode_d      = mode_q;
        frame_d     = frame_q;
        beat_d      = beat_q;
        flash_cnt_d = flash_cnt_q;

        // A request made while busy is remembered; consumed when a fade-out begins.
        pending_d = (state_q == RUN && state_d == FADE_OUT) ? 1'b0 : (pending_q || phrase);

        if (step_tick && state_q == FADE_OUT) fade_d = fade_q - 3'd1;
        if (step_tick && state_q == FADE_IN)  fade_d = fade_q + 3'd1;

        if (vsync_pulse) begin
            if (state_q == SWITCH) begin
                mode_d  = next_mode(mode_q, NUM_MODES);
                frame_d = '0;
            end else if (frame_q != FRAME_MAX) begin
                frame_d = frame_q + 10'd1;
            end
        end

        // Phrase restarts the bar and takes priority over a coincident beat.
        if (phrase) begin
            beat_d = '0;
        end else if (crotchet) begin
            beat_d = beat_q + 2'd1;
        end

        if (crotchet) begin
            flash_cnt_d = 4'(FLASH_FRAMES);
        end else if (vsync_pulse && flash_cnt_q != 4'd0) begin
            flash_cnt_d = flash_cnt_q - 4'd1;
        end
    end

    // Outputs decoded directly from registered state.
    always_comb begin
        mode       = mode_q;
        frame      = frame_q;
        beat       = beat_q;
        beat_flash = (flash_cnt_q != 4'd0);
        fade       = fade_q;
        busy       = (state_q != RUN);
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_mode_sequencer.sv
// Self-checking bench for mode_sequencer against a timeline-based reference model.
module tb_mode_sequencer;
  import mode_sequencer_pkg::*;

  localparam int F      = 2;
  localparam int NM     = 14;
  localparam int SW_K   = 7 * F + 1;   // frames after trigger at which the mode switches
  localparam int TR_END = 14 * F + 1;  // frames after trigger at which RUN resumes

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       crotchet = 1'b0;
  logic       phrase = 1'b0;
  logic       vsync_pulse = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] mode;
  logic [9:0] frame;
  logic [1:0] beat;
  logic       beat_flash;
  logic [2:0] fade;
  logic       busy;
  seq_state_t state_dbg;

  int checks = 0;
  int errors = 0;

  // reference model: transition expressed as frames elapsed since the trigger frame
  int m_k = -1;
  int m_mode = 0;
  int m_frame = 0;
  int m_beat = 0;
  int m_flash = 0;
  bit m_pend = 0;

  mode_sequencer #(
    .NUM_MODES(NM),
    .FADE_STEP_FRAMES(F),
    .FLASH_FRAMES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .crotchet(crotchet),
    .phrase(phrase),
    .vsync_pulse(vsync_pulse),
    .hold(hold),
    .mode(mode),
    .frame(frame),
    .beat(beat),
    .beat_flash(beat_flash),
    .fade(fade),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic int m_fade();
    if (m_k < 0) return 7;
    if (m_k <= 7 * F) return 7 - m_k / F;
    if (m_k == SW_K) return 0;
    return (m_k - SW_K) / F;
  endfunction

  function automatic logic [20:0] model_vec();
    return {4'(m_mode), 10'(m_frame), 2'(m_beat), (m_flash != 0), 3'(m_fade()), (m_k >= 0)};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {mode, frame, beat, beat_flash, fade, busy};
  endfunction

  task automatic model_step(input bit r, input bit ph, input bit cr, input bit vs, input bit hd);
    bit start;
    if (r) begin
      m_k = -1; m_mode = 0; m_frame = 0; m_beat = 0; m_flash = 0; m_pend = 0;
      return;
    end
    start = 0;
    if (vs) begin
      if (m_k < 0) begin
        if ((m_pend || ph) && !hd) begin
          m_k = 0;
          start = 1;
        end
      end else begin
        m_k++;
        if (m_k == TR_END) m_k = -1;
      end
      if (m_k == SW_K) begin
        m_frame = 0;
        m_mode = (m_mode + 1) % NM;
      end else if (m_frame < 1023) begin
        m_frame++;
      end
    end
    m_pend = start ? 1'b0 : (m_pend || ph);
    if (ph) m_beat = 0;
    else if (cr) m_beat = (m_beat + 1) % 4;
    if (cr) m_flash = 4;
    else if (vs && m_flash > 0) m_flash--;
  endtask

  // one clock with the given inputs; outputs are valid on return (#1 after the edge)
  task automatic step(input bit r, input bit ph, input bit cr, input bit vs, input bit hd);
    rst = r; phrase = ph; crotchet = cr; vsync_pulse = vs; hold = hd;
    @(posedge clk);
    model_step(r, ph, cr, vs, hd);
    #1;
    rst = 1'b0; phrase = 1'b0; crotchet = 1'b0; vsync_pulse = 1'b0;
  endtask

  // a few idle cycles followed by one vsync
  task automatic next_frame(input bit hd);
    int gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) step(0, 0, 0, 0, hd);
    step(0, 0, 0, 1, hd);
  endtask

  task automatic full_transition();
    step(0, 1, 0, 0, 0);
    for (int i = 0; i <= TR_END; i++) next_frame(0);
  endtask

  task automatic test_reset();
    logic [20:0] exp_v;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    exp_v = {4'd0, 10'd0, 2'd0, 1'b0, 3'd7, 1'b0};
    checks++;
    if (dut_vec() !== exp_v) begin
      errors++;
      $display("FAIL reset_vals got %h want %h", dut_vec(), exp_v);
    end
    for (int i = 0; i < 5; i++) next_frame(0);
    checks++;
    if ({mode, fade, frame, busy} !== {4'd0, 3'd7, 10'd5, 1'b0}) begin
      errors++;
      $display("FAIL idle_5_frames got mode=%0d fade=%0d frame=%0d busy=%0d want 0 7 5 0",
               mode, fade, frame, busy);
    end
  endtask

  task automatic test_transition();
    step(0, 1, 0, 0, 0);
    for (int n = 0; n <= TR_END; n++) begin
      next_frame(0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL transition_seq k=%0d got %h want %h", n, dut_vec(), model_vec());
      end
      if (n == 7 * F) begin
        checks++;
        if (fade !== 3'd0 || mode !== 4'd0) begin
          errors++;
          $display("FAIL fade_bottom got fade=%0d mode=%0d want 0 0", fade, mode);
        end
      end
      if (n == SW_K) begin
        checks++;
        if (mode !== 4'd1 || frame !== 10'd0) begin
          errors++;
          $display("FAIL switch_mode got mode=%0d frame=%0d want 1 0", mode, frame);
        end
      end
      if (n == TR_END - 1) begin
        checks++;
        if (busy !== 1'b1 || fade !== 3'd6) begin
          errors++;
          $display("FAIL before_end got busy=%0d fade=%0d want 1 6", busy, fade);
        end
      end
    end
    checks++;
    if (busy !== 1'b0 || fade !== 3'd7) begin
      errors++;
      $display("FAIL transition_end got busy=%0d fade=%0d want 0 7", busy, fade);
    end
  endtask

  task automatic test_wrap();
    for (int t = 0; t < 20 && m_mode != 13; t++) full_transition();
    checks++;
    if (mode !== 4'd13) begin
      errors++;
      $display("FAIL reach_13 got %0d want 13", mode);
    end
    full_transition();
    checks++;
    if (mode !== 4'd0 || dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL wrap_to_0 got mode=%0d vec %h want 0 vec %h", mode, dut_vec(), model_vec());
    end
    for (int t = 0; t < 20 && m_mode != 5; t++) full_transition();
    full_transition();
    checks++;
    if (mode !== 4'd6) begin
      errors++;
      $display("FAIL mode_5_to_6 got %0d want 6", mode);
    end
  endtask

  task automatic test_back_to_back();
    int start_mode = m_mode;
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) next_frame(0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0);
      next_frame(0);
    end
    for (int i = 0; i < TR_END + 4 && m_k >= 0; i++) next_frame(0);
    checks++;
    if (busy !== 1'b0 || mode !== 4'((start_mode + 1) % NM)) begin
      errors++;
      $display("FAIL back_in_run got busy=%0d mode=%0d want 0 %0d", busy, mode, (start_mode + 1) % NM);
    end
    next_frame(0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL queued_start got busy=%0d want 1", busy);
    end
    for (int i = 0; i < TR_END + 6; i++) begin
      next_frame(0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL queued_seq i=%0d got %h want %h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if (busy !== 1'b0 || mode !== 4'((start_mode + 2) % NM)) begin
      errors++;
      $display("FAIL one_extra got busy=%0d mode=%0d want 0 %0d", busy, mode, (start_mode + 2) % NM);
    end
    step(0, 1, 0, 1, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL phrase_vsync_same got busy=%0d want 1", busy);
    end
    for (int i = 0; i < TR_END + 1; i++) next_frame(0);
  endtask

  task automatic test_hold();
    int start_mode = m_mode;
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 50; i++) next_frame(1);
    checks++;
    if (mode !== 4'(start_mode) || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_blocks got mode=%0d busy=%0d want %0d 0", mode, busy, start_mode);
    end
    step(0, 0, 0, 0, 0);
    next_frame(0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_release got busy=%0d want 1", busy);
    end
    for (int i = 0; i < 5; i++) next_frame(1);
    checks++;
    if (busy !== 1'b1 || dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL hold_mid_transition got %h want %h", dut_vec(), model_vec());
    end
    for (int i = 0; i < TR_END; i++) next_frame(0);
    for (int i = 0; i < 1100; i++) next_frame(0);
    checks++;
    if (frame !== 10'd1023 || dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL frame_saturate got frame=%0d want 1023", frame);
    end
  endtask

  task automatic test_beat();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, $urandom_range(0, 1), 0);
    end
    checks++;
    if (beat !== 2'd1 || beat !== 2'(m_beat)) begin
      errors++;
      $display("FAIL beat_count got %0d want 1", beat);
    end
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) next_frame(0);
    checks++;
    if (beat_flash !== 1'b1) begin
      errors++;
      $display("FAIL flash_held got %0d want 1", beat_flash);
    end
    next_frame(0);
    checks++;
    if (beat_flash !== 1'b0) begin
      errors++;
      $display("FAIL flash_expired got %0d want 0", beat_flash);
    end
    step(0, 1, 1, 0, 0);
    checks++;
    if (beat !== 2'd0 || beat_flash !== 1'b1) begin
      errors++;
      $display("FAIL phrase_beats_crotchet got beat=%0d flash=%0d want 0 1", beat, beat_flash);
    end
    step(0, 0, 1, 1, 0);
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL crotchet_vs_vsync got %h want %h", dut_vec(), model_vec());
    end
    for (int i = 0; i < SW_K + 3; i++) next_frame(0);
    checks++;
    if (busy !== 1'b1 || dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL mid_fade_in got %h want %h", dut_vec(), model_vec());
    end
    step(1, 0, 0, 0, 0);
    checks++;
    if (dut_vec() !== {4'd0, 10'd0, 2'd0, 1'b0, 3'd7, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_fade got %h want %h", dut_vec(), {4'd0, 10'd0, 2'd0, 1'b0, 3'd7, 1'b0});
    end
  endtask

  task automatic test_random();
    bit hd = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) hd = !hd;
      step($urandom_range(0, 599) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, hd);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random_cycle i=%0d got %h want %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_transition();
    test_wrap();
    test_back_to_back();
    test_hold();
    test_beat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
